// File: rtl/lm75_i2c_master.sv
// I2C master for single LM75-style register transactions: START, address+R/W,
// optional pointer byte, 0-2 data bytes either direction, STOP. Open-drain SDA.
module lm75_i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start_op,
  input  logic        Rw,
  input  logic [6:0]  Addr,
  input  logic [1:0]  Pointer,
  input  logic [1:0]  Nbytes,
  input  logic [15:0] Wr_data,
  output logic        Busy,
  output logic        Done,
  output logic        Ack_err,
  output logic [15:0] Rd_data,
  output logic        Scl,
  inout  wire         Sda
);

  typedef enum logic [2:0] {IDLE, START, TX_BYTE, ACK_RX, RX_BYTE, ACK_TX, STOP} state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    sh_q, sh_d;
  logic          rw_q, rw_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    nb_q, nb_d;
  logic [15:0]   wd_q, wd_d;
  logic [15:0]   rd_buf_q, rd_buf_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          nack_q, nack_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;

  logic          tick;
  logic [1:0]    last;
  logic [1:0]    nxt_byte;
  logic          sda_in;

  // Sampled straight off the pad on the last clock of the SCL-high window.
  assign sda_in   = Sda;
  assign tick     = (state_q != IDLE) && (div_q == DW'(CLK_DIV - 1));
  assign last     = rw_q ? nb_q : nb_q + 2'd1;
  assign nxt_byte = byte_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    div_d     = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    nb_d      = nb_q;
    wd_d      = wd_q;
    rd_buf_d  = rd_buf_q;
    rd_data_d = rd_data_q;
    nack_d    = nack_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;

    case (state_q)
      IDLE: begin
        if (Start_op) begin
          state_d   = START;
          div_d     = '0;
          qtr_d     = 2'd0;
          bit_d     = 3'd7;
          byte_d    = 2'd0;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          rw_d      = Rw;
          ptr_d     = Pointer;
          wd_d      = Wr_data;
          sh_d      = {Addr, Rw};
          rd_buf_d  = '0;
          if (Nbytes == 2'd3)             nb_d = 2'd2;
          else if (Rw && Nbytes == 2'd0)  nb_d = 2'd1;
          else                            nb_d = Nbytes;
        end
      end
      START: begin
        if (tick) begin
          if (qtr_q == 2'd1) begin
            state_d = TX_BYTE;
            qtr_d   = 2'd0;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      TX_BYTE: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            bit_d = bit_q - 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
            if (bit_q == 3'd0) state_d = ACK_RX;
          end
        end
      end
      ACK_RX: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) nack_d = sda_in;
          if (qtr_q == 2'd3) begin
            if (nack_q) begin
              ack_err_d = 1'b1;
              state_d   = STOP;
            end else if (byte_q == last) begin
              state_d = STOP;
            end else begin
              byte_d = nxt_byte;
              if (rw_q) begin
                state_d = RX_BYTE;
              end else begin
                state_d = TX_BYTE;
                case (nxt_byte)
                  2'd1:    sh_d = {6'b0, ptr_q};
                  2'd2:    sh_d = wd_q[15:8];
                  default: sh_d = wd_q[7:0];
                endcase
              end
            end
          end
        end
      end
      RX_BYTE: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) sh_d = {sh_q[6:0], sda_in};
          if (qtr_q == 2'd3) begin
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) begin
              state_d = ACK_TX;
              if (byte_q == 2'd1) rd_buf_d[15:8] = sh_q;
              else                rd_buf_d[7:0]  = sh_q;
            end
          end
        end
      end
      ACK_TX: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            if (byte_q == last) begin
              state_d = STOP;
            end else begin
              byte_d  = nxt_byte;
              state_d = RX_BYTE;
            end
          end
        end
      end
      STOP: begin
        // One extra cycle in STOP after Done so a coincident Start_op is dropped.
        if (done_q) begin
          state_d = IDLE;
        end else if (tick) begin
          if (qtr_q == 2'd2) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            if (rw_q && !ack_err_q) rd_data_d = rd_buf_q;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus pins are registered from the next-state view so they line up with quarters.
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_d)
      START: begin
        scl_d    = (qtr_d == 2'd0);
        sda_oe_d = 1'b1;
      end
      TX_BYTE: begin
        scl_d    = qtr_d inside {2'd1, 2'd2};
        sda_oe_d = ~sh_d[7];
      end
      ACK_RX, RX_BYTE: begin
        scl_d    = qtr_d inside {2'd1, 2'd2};
        sda_oe_d = 1'b0;
      end
      ACK_TX: begin
        scl_d    = qtr_d inside {2'd1, 2'd2};
        sda_oe_d = (byte_d != last);
      end
      STOP: begin
        scl_d    = (qtr_d != 2'd0);
        sda_oe_d = (qtr_d != 2'd2);
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd7;
      byte_q    <= 2'd0;
      sh_q      <= '0;
      rw_q      <= 1'b0;
      ptr_q     <= 2'd0;
      nb_q      <= 2'd0;
      wd_q      <= '0;
      rd_buf_q  <= '0;
      rd_data_q <= '0;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sh_q      <= sh_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      nb_q      <= nb_d;
      wd_q      <= wd_d;
      rd_buf_q  <= rd_buf_d;
      rd_data_q <= rd_data_d;
      nack_q    <= nack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Ack_err = ack_err_q;
  assign Rd_data = rd_data_q;
  assign Scl     = scl_q;
  assign Sda     = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_lm75_i2c_master.sv
// Directed bench for lm75_i2c_master with a behavioural open-drain LM75 slave model.
module tb_lm75_i2c_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_op = 1'b0;
  logic        rw = 1'b0;
  logic [6:0]  addr = '0;
  logic [1:0]  pointer = '0;
  logic [1:0]  nbytes = '0;
  logic [15:0] wr_data = '0;
  logic        busy, done, ack_err, scl;
  logic [15:0] rd_data;
  wire         sda;

  int n_assert = 0;
  int n_fail   = 0;

  lm75_i2c_master #(.CLK_DIV(4)) dut (
    .Clk(clk), .Rst(rst), .Start_op(start_op), .Rw(rw), .Addr(addr),
    .Pointer(pointer), .Nbytes(nbytes), .Wr_data(wr_data), .Busy(busy),
    .Done(done), .Ack_err(ack_err), .Rd_data(rd_data), .Scl(scl), .Sda(sda)
  );

  always #5 clk = ~clk;

  pullup (sda);

  // Slave model: address 7'h48, returns tx_q bytes on reads, logs written bytes.
  localparam logic [6:0] SLV_ADDR = 7'h48;
  logic       slv_drive = 1'b0;
  logic       active = 1'b0, rd_mode = 1'b0, addressed = 1'b0, tx_on = 1'b0;
  logic       mack_last = 1'b1;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0] sh = '0, cur_tx = '0;
  logic [7:0] tx_q [2];
  logic [7:0] rx_log [$];
  logic       mack_log [$];
  int         slot = 0, byten = 0, hi_chg = 0;

  assign sda = slv_drive ? 1'b0 : 1'bz;

  always @(scl or sda) begin
    if (scl === 1'b1 && scl_p === 1'b1 && sda !== sda_p) hi_chg++;
    if (scl === 1'b1 && scl_p === 1'b1 && sda_p === 1'b1 && sda === 1'b0) begin
      active = 1'b1; slot = 0; byten = 0; rd_mode = 1'b0; addressed = 1'b0;
      tx_on = 1'b0; slv_drive = 1'b0;
    end else if (scl === 1'b1 && scl_p === 1'b1 && sda_p === 1'b0 && sda === 1'b1) begin
      active = 1'b0; tx_on = 1'b0; slv_drive = 1'b0;
    end else if (active && scl_p === 1'b0 && scl === 1'b1) begin
      if (slot < 8) begin
        if (!(rd_mode && byten > 0)) sh = {sh[6:0], sda};
      end else if (rd_mode && byten > 0) begin
        mack_log.push_back(sda);
        mack_last = sda;
      end
      slot++;
    end else if (active && scl_p === 1'b1 && scl === 1'b0) begin
      if (slot == 8) begin
        if (byten == 0) begin
          addressed = (sh[7:1] == SLV_ADDR);
          rd_mode   = sh[0];
          rx_log.push_back(sh);
          slv_drive = addressed;
        end else if (!rd_mode) begin
          rx_log.push_back(sh);
          slv_drive = addressed;
        end else begin
          slv_drive = 1'b0;
        end
      end else if (slot == 9) begin
        slot = 0;
        byten++;
        slv_drive = 1'b0;
        tx_on = 1'b0;
        if (rd_mode && addressed && byten <= 2 && (byten == 1 || mack_last == 1'b0)) begin
          tx_on     = 1'b1;
          cur_tx    = tx_q[byten-1];
          slv_drive = ~cur_tx[7];
        end
      end else if (slot >= 1 && slot <= 7 && tx_on) begin
        slv_drive = ~cur_tx[7-slot];
      end
    end
    scl_p = scl;
    sda_p = sda;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the master idle; returns at the first negedge after acceptance.
  task automatic launch(input logic r, input logic [6:0] a, input logic [1:0] p,
                        input logic [1:0] nb, input logic [15:0] wd);
    rw = r; addr = a; pointer = p; nbytes = nb; wr_data = wd; start_op = 1'b1;
    @(negedge clk);
    start_op = 1'b0;
  endtask

  task automatic wait_done(output int cnt, output logic ok);
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1) cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int   cnt, pre;
    logic ok;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_rd_data", rd_data, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // 2-byte read from 0x48
    tx_q[0] = 8'h19; tx_q[1] = 8'h80;
    rx_log.delete(); mack_log.delete();
    launch(1'b1, 7'h48, 2'd0, 2'd2, 16'h0);
    chk("rd2_busy_rise", busy, 1);
    wait_done(cnt, ok);
    chk("rd2_done", ok, 1);
    chk("rd2_busy_len", cnt, 452);
    chk("rd2_busy_fall", busy, 0);
    chk("rd2_data", rd_data, 16'h1980);
    chk("rd2_ack_err", ack_err, 0);
    chk("rd2_addr_byte", rx_log[0], 8'h91);
    chk("rd2_mack_n", mack_log.size(), 2);
    chk("rd2_mack0", mack_log[0], 0);
    chk("rd2_mack1", mack_log[1], 1);
    @(negedge clk);
    chk("rd2_done_pulse", done, 0);

    // Write pointer 2 + two data bytes
    rx_log.delete(); hi_chg = 0;
    launch(1'b0, 7'h48, 2'd2, 2'd2, 16'h4B00);
    wait_done(cnt, ok);
    chk("wr2_done", ok, 1);
    chk("wr2_busy_len", cnt, 596);
    chk("wr2_nbytes", rx_log.size(), 4);
    chk("wr2_b0", rx_log[0], 8'h90);
    chk("wr2_b1", rx_log[1], 8'h02);
    chk("wr2_b2", rx_log[2], 8'h4B);
    chk("wr2_b3", rx_log[3], 8'h00);
    chk("wr2_sda_hi_changes", hi_chg, 2);
    chk("wr2_ack_err", ack_err, 0);
    chk("wr2_rd_unchanged", rd_data, 16'h1980);
    @(negedge clk);

    // Address NACK at 0x49
    rx_log.delete(); mack_log.delete();
    launch(1'b1, 7'h49, 2'd0, 2'd2, 16'h0);
    wait_done(cnt, ok);
    chk("nack_done", ok, 1);
    chk("nack_busy_len", cnt, 164);
    chk("nack_ack_err", ack_err, 1);
    chk("nack_rd_unchanged", rd_data, 16'h1980);
    chk("nack_addr_byte", rx_log[0], 8'h93);
    @(negedge clk);
    chk("nack_ack_err_held", ack_err, 1);

    // Pointer-only write, Nbytes=0
    rx_log.delete();
    launch(1'b0, 7'h48, 2'd1, 2'd0, 16'hFFFF);
    chk("ptr_ack_err_clr", ack_err, 0);
    wait_done(cnt, ok);
    chk("ptr_done", ok, 1);
    chk("ptr_busy_len", cnt, 308);
    chk("ptr_nbytes", rx_log.size(), 2);
    chk("ptr_b0", rx_log[0], 8'h90);
    chk("ptr_b1", rx_log[1], 8'h01);

    // Start_op coincident with Done is dropped, accepted one cycle later: 1-byte read
    tx_q[0] = 8'hE7; tx_q[1] = 8'h55;
    rx_log.delete(); mack_log.delete();
    rw = 1'b1; addr = 7'h48; pointer = 2'd0; nbytes = 2'd0; start_op = 1'b1;
    @(negedge clk);
    chk("coinc_ignored", busy, 0);
    @(negedge clk);
    start_op = 1'b0;
    chk("coinc_accepted", busy, 1);
    wait_done(cnt, ok);
    chk("rd1_done", ok, 1);
    chk("rd1_busy_len", cnt, 308);
    chk("rd1_data", rd_data, 16'hE700);
    chk("rd1_mack_n", mack_log.size(), 1);
    chk("rd1_mack0", mack_log[0], 1);
    @(negedge clk);

    // Start_op pulsed mid-transaction with different command is ignored
    tx_q[0] = 8'h12; tx_q[1] = 8'h34;
    rx_log.delete(); mack_log.delete();
    launch(1'b1, 7'h48, 2'd0, 2'd2, 16'h0);
    pre = 0;
    repeat (50) begin @(negedge clk); pre++; end
    rw = 1'b0; addr = 7'h11; start_op = 1'b1;
    @(negedge clk); pre++;
    start_op = 1'b0;
    wait_done(cnt, ok);
    chk("mid_done", ok, 1);
    chk("mid_busy_len", pre + cnt, 452);
    chk("mid_data", rd_data, 16'h1234);
    chk("mid_nbytes_wr", rx_log.size(), 1);
    chk("mid_addr_byte", rx_log[0], 8'h91);
    @(negedge clk);

    // Reset mid-byte: bit 6 of 0x90 with SCL high and SDA low
    launch(1'b0, 7'h48, 2'd2, 2'd2, 16'h4B00);
    repeat (28) @(negedge clk);
    chk("mid_byte_scl", scl, 1);
    chk("mid_byte_sda", sda, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_scl", scl, 1);
    chk("arst_sda", sda, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rd_data", rd_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Read right after reset release
    tx_q[0] = 8'h5A; tx_q[1] = 8'hA5;
    rx_log.delete(); mack_log.delete();
    launch(1'b1, 7'h48, 2'd0, 2'd3, 16'h0);
    chk("post_rst_busy", busy, 1);
    wait_done(cnt, ok);
    chk("post_rst_done", ok, 1);
    chk("post_rst_busy_len", cnt, 452);
    chk("post_rst_data", rd_data, 16'h5AA5);
    chk("post_rst_ack_err", ack_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
